// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with leading-zero mask.
// Latency: start accepted at edge N -> done pulse and results after edge N+BIN_W.
// Backpressure: start is ignored while busy (not queued); results hold until the next done.
module bin2bcd_seq #(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic [DIGITS-1:0]     lz_mask
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [31:0]       MAXV   = 32'(10 ** DIGITS - 1);
    localparam logic [BW-1:0]     NINES  = {DIGITS{4'h9}};
    localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_n;
    logic [BIN_W-1:0]  shreg, shreg_n;
    logic [BW-1:0]     scr, scr_n, adj, shifted, final_bcd;
    logic [CW-1:0]     cnt, cnt_n;
    logic              ovf_pend, ovf_pend_n;
    logic              done_n, ovf_n;
    logic [BW-1:0]     bcd_n;
    logic [DIGITS-1:0] lz_n;
    logic              unused_msb;

    // Bit i set when digit i and every digit above it are zero; digit 0 is never blanked.
    function automatic logic [DIGITS-1:0] lz_of(input logic [BW-1:0] v);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (v[4*i +: 4] == 4'h0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (scr[4*i +: 4] >= 4'd5) ? scr[4*i +: 4] + 4'd3 : scr[4*i +: 4];
        end
    end

    // The adjusted scratch MSB falls off the top of the shift.
    assign shifted    = {adj[BW-2:0], shreg[BIN_W-1]};
    assign unused_msb = adj[BW-1];
    assign busy       = (state == SHIFT);

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        scr_n      = scr;
        cnt_n      = cnt;
        ovf_pend_n = ovf_pend;
        done_n     = 1'b0;
        bcd_n      = bcd_out;
        ovf_n      = ovf;
        lz_n       = lz_mask;
        final_bcd  = ovf_pend ? NINES : shifted;
        case (state)
            IDLE: begin
                if (start) begin
                    shreg_n    = bin_in;
                    scr_n      = '0;
                    cnt_n      = '0;
                    ovf_pend_n = (32'(bin_in) > MAXV);
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                scr_n   = shifted;
                shreg_n = shreg << 1;
                cnt_n   = cnt + CW'(1);
                if (cnt == CW'(BIN_W - 1)) begin
                    bcd_n   = final_bcd;
                    ovf_n   = ovf_pend;
                    lz_n    = lz_of(final_bcd);
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            scr      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            ovf      <= 1'b0;
            lz_mask  <= LZ_RST;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            scr      <= scr_n;
            cnt      <= cnt_n;
            ovf_pend <= ovf_pend_n;
            done     <= done_n;
            bcd_out  <= bcd_n;
            ovf      <= ovf_n;
            lz_mask  <= lz_n;
        end
    end

endmodule
